// File: rtl/muldiv_pkg.sv
// Shared op/state encodings and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_ACC  = 2'd3;

    // Operands up to 64 bits are sign-extended into this width before taking |x|.
    localparam int ABS_W = 64;

    function automatic logic [ABS_W-1:0] abs_val(input logic signed [ABS_W-1:0] v);
        return (v < 0) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage (master) and muldiv_unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             cancel;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, cancel, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_step.sv
// One CALC iteration: STEP_BITS chained shift-add (MUL) or restoring subtract-compare (DIV) steps.
// Purely combinational; {hi,lo} is the product / remainder:quotient shift pair.
module muldiv_step #(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH-1:0] h;
    logic [WIDTH-1:0] l;
    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] diff;

    always_comb begin
        h    = hi_in;
        l    = lo_in;
        sum  = '0;
        diff = '0;
        for (int i = 0; i < STEP_BITS; i++) begin
            if (is_div) begin
                // Partial remainder stays below the divisor, so the top diff bits are zero on success.
                diff = {1'b0, h, l[WIDTH-1]} - {2'b00, opnd};
                if (diff[WIDTH+1:WIDTH] == 2'b00) h = diff[WIDTH-1:0];
                else                              h = {h[WIDTH-2:0], l[WIDTH-1]};
                l = {l[WIDTH-2:0], (diff[WIDTH+1:WIDTH] == 2'b00)};
            end else begin
                sum = {1'b0, h} + (l[0] ? {1'b0, opnd} : '0);
                h   = sum[WIDTH:1];
                l   = {sum[0], l[WIDTH-1:1]};
            end
        end
        hi_out = h;
        lo_out = l;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MUL/DIV with HI/LO; MADD/MADDU accumulate only when `MULDIV_MADD_EN is defined.
// Done at N+1 cycles after accept (N+2 MADD, 1 for no-ops); start is ignored while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int STEP_BITS = 1
) (
    input logic     sys_clk,
    input logic     rst_n,
    muldiv_if.slave bus
);

    localparam int N     = WIDTH / STEP_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             is_div, neg_res, neg_rem, nop, done_q;
    logic [WIDTH-1:0] step_hi, step_lo;
`ifdef MULDIV_MADD_EN
    logic             is_madd;
`endif

    logic             op_madd, op_arith, op_div, op_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    always_comb begin
        op_madd = 1'b0;
`ifdef MULDIV_MADD_EN
        op_madd = (bus.op == OP_MADD) || (bus.op == OP_MADDU);
`endif
        op_arith  = (bus.op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) || op_madd;
        op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.src_a[WIDTH-1];
        b_neg     = op_signed & bus.src_b[WIDTH-1];
        a_mag     = a_neg ? WIDTH'(abs_val(ABS_W'($signed(bus.src_a)))) : bus.src_a;
        b_mag     = b_neg ? WIDTH'(abs_val(ABS_W'($signed(bus.src_b)))) : bus.src_b;
    end

    muldiv_step #(
        .WIDTH     (WIDTH),
        .STEP_BITS (STEP_BITS)
    ) u_step (
        .is_div (is_div),
        .hi_in  (acc_hi),
        .lo_in  (acc_lo),
        .opnd   (opnd),
        .hi_out (step_hi),
        .lo_out (step_lo)
    );

    // Sign fix-up of the magnitude result: remainder follows the dividend.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   res_hi, res_lo;

    always_comb begin
        prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        if (is_div) begin
            res_hi = neg_rem ? -acc_hi : acc_hi;
            res_lo = neg_res ? -acc_lo : acc_lo;
        end else begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            opnd    <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            nop     <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULDIV_MADD_EN
            is_madd <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.wdata;
                    if (bus.lo_we) lo_q <= bus.wdata;
                    if (bus.start && !bus.cancel) begin
                        is_div  <= op_div;
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        nop     <= !op_arith;
                        acc_hi  <= '0;
                        acc_lo  <= op_div ? a_mag : b_mag;
                        opnd    <= op_div ? b_mag : a_mag;
                        cnt     <= CNT_W'(N - 1);
                        state   <= op_arith ? S_CALC : S_FIX;
`ifdef MULDIV_MADD_EN
                        is_madd <= op_madd;
`endif
                    end
                end
                S_CALC: begin
                    if (bus.cancel) begin
                        state <= S_IDLE;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        cnt    <= cnt - CNT_W'(1);
                        if (cnt == '0) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    if (!bus.cancel && nop) begin
                        done_q <= 1'b1;
                    end else if (!bus.cancel) begin
`ifdef MULDIV_MADD_EN
                        if (is_madd) begin
                            acc_hi <= res_hi;
                            acc_lo <= res_lo;
                            state  <= S_ACC;
                        end else
`endif
                        begin
                            hi_q   <= res_hi;
                            lo_q   <= res_lo;
                            done_q <= 1'b1;
                        end
                    end
                end
`ifdef MULDIV_MADD_EN
                S_ACC: begin
                    state <= S_IDLE;
                    if (!bus.cancel) begin
                        {hi_q, lo_q} <= {hi_q, lo_q} + {acc_hi, acc_lo};
                        done_q       <= 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboarded random/directed bench for muldiv_unit; expectations follow `MULDIV_MADD_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W  = 32;
    localparam int SB = 1;
    localparam int N  = W / SB;
`ifdef MULDIV_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic rst_n   = 1'b0;
    always #5 sys_clk = ~sys_clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .STEP_BITS(SB)) dut (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
        int           t0;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;
    logic [W-1:0] m_hi  = '0;
    logic [W-1:0] m_lo  = '0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic; divide-by-zero gives quotient magnitude all-ones, remainder = dividend.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint      sa, sb;
        logic [63:0] up;
        logic [31:0] q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (o)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return up;
            OP_DIV: begin
                if (b == 0) begin
                    q = (sa < 0) ? 32'd1 : 32'hFFFFFFFF;
                    r = a;
                end else begin
                    q = 32'(sa / sb);
                    r = 32'(sa % sb);
                end
                return {r, q};
            end
            OP_DIVU:  return (b == 0) ? {a, 32'hFFFFFFFF} : {a % b, a / b};
            OP_MADD:  return MADD_EN ? cur + 64'(sa * sb) : cur;
            OP_MADDU: return MADD_EN ? cur + up : cur;
            default:  return cur;
        endcase
    endfunction

    function automatic int lat_of(input logic [2:0] o);
        if (o inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) return N + 1;
        if ((o == OP_MADD || o == OP_MADDU) && MADD_EN)    return N + 2;
        return 1;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'($urandom_range(0, 20));
            5:       return -32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge sys_clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'(bus.done), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("hi", 64'(bus.hi), 64'(e.hi));
                chk("lo", 64'(bus.lo), 64'(e.lo));
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
                chk("busy_at_done", 64'(bus.busy), 64'(0));
            end
        end
    end

    task automatic mt(input bit is_hi, input logic [31:0] d);
        @(negedge sys_clk);
        bus.hi_we = is_hi;
        bus.lo_we = !is_hi;
        bus.wdata = d;
        @(negedge sys_clk);
        bus.hi_we = 1'b0;
        bus.lo_we = 1'b0;
        if (is_hi) begin
            m_hi = d;
            chk("mthi", 64'(bus.hi), 64'(d));
        end else begin
            m_lo = d;
            chk("mtlo", 64'(bus.lo), 64'(d));
        end
    endtask

    // cancel_at / poke_at: cycle after accept to raise cancel / inject a start+HI/LO write (-1 = none).
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int cancel_at, input int poke_at);
        logic [63:0] r;
        exp_t        e;
        int          lim;
        @(negedge sys_clk);
        chk("idle_before_start", 64'(bus.busy), 64'(0));
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge sys_clk);
        bus.start = 1'b0;
        chk("busy_after_accept", 64'(bus.busy), 64'(1));
        if (cancel_at < 0) begin
            r     = ref_result(o, a, b, {m_hi, m_lo});
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.lat = lat_of(o);
            e.t0  = cyc;
            exp_q.push_back(e);
            m_hi  = e.hi;
            m_lo  = e.lo;
            lim   = 3 * N + 10;
        end else begin
            lim = cancel_at + N + 5;
        end
        for (int k = 1; k <= lim; k++) begin
            @(negedge sys_clk);
            if (k == poke_at) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
                bus.hi_we = 1'b1;
                bus.lo_we = 1'b1;
                bus.wdata = $urandom;
            end
            if (k == poke_at + 1) begin
                bus.start = 1'b0;
                bus.hi_we = 1'b0;
                bus.lo_we = 1'b0;
            end
            if (k == cancel_at) bus.cancel = 1'b1;
            if (k == cancel_at + 1) begin
                bus.cancel = 1'b0;
                chk("busy_after_cancel", 64'(bus.busy), 64'(0));
                chk("hi_after_cancel", 64'(bus.hi), 64'(m_hi));
                chk("lo_after_cancel", 64'(bus.lo), 64'(m_lo));
            end
            if (cancel_at < 0 && exp_q.size() == 0) break;
        end
        if (cancel_at < 0) begin
            chk("done_timeout", 64'(exp_q.size()), 64'(0));
            exp_q.delete();
        end
    endtask

    initial begin : stim
        logic [2:0] o;
        bus.start = 1'b0; bus.op = 3'd0; bus.src_a = '0; bus.src_b = '0;
        bus.cancel = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

        repeat (2) @(negedge sys_clk);
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_done", 64'(bus.done), 64'(0));
        chk("rst_hi", 64'(bus.hi), 64'(0));
        chk("rst_lo", 64'(bus.lo), 64'(0));
        rst_n = 1'b1;

        mt(1'b0, 32'h00001234);
        mt(1'b1, 32'hCAFE0001);

        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, -1);
        run_op(OP_MULT,  32'hFFFFFFF9, 32'd6,        -1, 5);
        run_op(OP_DIV,   32'hFFFFFFF9, 32'd2,        -1, -1);
        run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, -1, 3);
        run_op(OP_DIVU,  32'd5,        32'd0,        -1, -1);
        run_op(OP_DIV,   32'hFFFFFFF7, 32'd0,        -1, -1);
        run_op(OP_DIVU,  32'd100,      32'd7,        -1, -1);
        run_op(3'b110,   32'd9,        32'd9,        -1, -1);
        run_op(3'b111,   32'd9,        32'd9,        -1, -1);

        mt(1'b1, 32'h00000000);
        mt(1'b0, 32'hFFFFFFFF);
        run_op(OP_MADDU, 32'd1, 32'd1, -1, -1);
        run_op(OP_MADD,  32'hFFFFFFFD, 32'd5, -1, -1);

        run_op(OP_MULTU, 32'd3, 32'd4, 10, 5);
        run_op(OP_DIVU, 32'd1000, 32'd7, N, -1);

        @(negedge sys_clk);
        bus.start = 1'b1; bus.cancel = 1'b1; bus.op = OP_MULTU;
        bus.src_a = 32'd3; bus.src_b = 32'd3;
        @(negedge sys_clk);
        bus.start = 1'b0; bus.cancel = 1'b0;
        chk("start_with_cancel_ignored", 64'(bus.busy), 64'(0));
        repeat (N + 4) @(negedge sys_clk);
        chk("hi_kept", 64'(bus.hi), 64'(m_hi));
        chk("lo_kept", 64'(bus.lo), 64'(m_lo));

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) mt(1'($urandom_range(0, 1)), $urandom);
            o = 3'($urandom_range(0, 7));
            if (o <= OP_DIVU && $urandom_range(0, 5) == 0)
                run_op(o, pick(), pick(), $urandom_range(1, N), -1);
            else
                run_op(o, pick(), pick(), -1, (o <= OP_DIVU) ? $urandom_range(2, N - 2) : -1);
        end

        mt(1'b0, 32'hA5A5A5A5);
        @(negedge sys_clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.src_a = $urandom; bus.src_b = $urandom;
        @(negedge sys_clk);
        bus.start = 1'b0;
        repeat (6) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midcalc_rst_busy", 64'(bus.busy), 64'(0));
        chk("midcalc_rst_hi", 64'(bus.hi), 64'(0));
        chk("midcalc_rst_lo", 64'(bus.lo), 64'(0));
        m_hi = '0;
        m_lo = '0;
        exp_q.delete();
        @(negedge sys_clk);
        rst_n = 1'b1;
        run_op(OP_MULT, pick(), pick(), -1, -1);

        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no end of test, expected completion within 50000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
